// File: rtl/goomba_ctrl.sv
// Enemy controller: four goomba slots sharing one patrol/collision engine,
// scanned one slot per cycle on every game tick.
module goomba_ctrl #(
  parameter int TICK_DIV     = 2000000,
  parameter int PATROL_LEN   = 100,
  parameter int SQUASH_TICKS = 5,
  parameter int HIT_W        = 12,
  parameter int SPAWN_X0     = 112,
  parameter int SPAWN_X1     = 300,
  parameter int SPAWN_X2     = 520,
  parameter int SPAWN_X3     = 700,
  parameter int SPAWN_Y      = 366
) (
  input  logic       sys_clk,
  input  logic       RST,
  input  logic [9:0] char_X,
  input  logic [9:0] char_Y,
  input  logic       char_falling,
  input  logic [9:0] bg_pos,
  input  logic [1:0] rd_slot,
  output logic [9:0] rd_x,
  output logic [9:0] rd_y,
  output logic       rd_en,
  output logic       rd_squash,
  output logic       death,
  output logic       stomp,
  output logic [1:0] stomp_slot,
  output logic [2:0] alive_cnt
);
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int LW = (PATROL_LEN > 1) ? $clog2(PATROL_LEN) : 1;
  localparam int SW = (SQUASH_TICKS > 1) ? $clog2(SQUASH_TICKS) : 1;
  localparam logic [3:0][9:0] SPAWN_X = {10'(SPAWN_X3), 10'(SPAWN_X2),
                                         10'(SPAWN_X1), 10'(SPAWN_X0)};
  localparam logic [10:0] GY = 11'(SPAWN_Y);

  typedef enum logic [2:0] {IDLE, S0, S1, S2, S3, REPORT} scan_t;
  typedef enum logic [1:0] {ALIVE, SQUASH, DEAD} slot_st_t;
  typedef struct packed {
    slot_st_t        st;
    logic [9:0]      x;
    logic            dir;   // 1 = right
    logic [LW-1:0]   leg;
    logic [SW-1:0]   sq;
  } slot_t;

  scan_t             state, state_nxt;
  slot_t [3:0]       slots;
  slot_t             s, s_nxt;
  logic [TW-1:0]     tick_cnt;
  logic              tick_wrap, in_slot, stomp_hit, side_hit;
  logic [1:0]        cur;
  logic [9:0]        gx;
  logic [10:0]       dx, adx, cy16;
  logic              xhit, stomp_n, side_n, hit_stomp, hit_side;
  logic [2:0]        alive_now;

  assign tick_wrap = (tick_cnt == TW'(TICK_DIV - 1));
  assign in_slot   = (state == S0) || (state == S1) || (state == S2) || (state == S3);
  assign cur       = 2'(state - S0);

  // Shared engine: post-step position and contact classification for slot cur
  always_comb begin
    s    = slots[cur];
    gx   = s.dir ? s.x + 10'd1 : s.x - 10'd1;
    dx   = {1'b0, char_X} - {1'b0, gx};
    adx  = dx[10] ? (~dx + 11'd1) : dx;
    xhit = adx < 11'(HIT_W);
    cy16 = {1'b0, char_Y} + 11'd16;
    stomp_n = xhit && char_falling && (cy16 >= GY) && (cy16 <= GY + 11'd4);
    side_n  = xhit && !stomp_n && (cy16 > GY + 11'd4) && ({1'b0, char_Y} < GY + 11'd16);
    hit_stomp = in_slot && (s.st == ALIVE) && stomp_n;
    hit_side  = in_slot && (s.st == ALIVE) && side_n;

    s_nxt = s;
    case (s.st)
      ALIVE: begin
        s_nxt.x = gx;
        if (s.leg == LW'(PATROL_LEN - 1)) begin
          s_nxt.leg = '0;
          s_nxt.dir = ~s.dir;
        end else begin
          s_nxt.leg = s.leg + 1'b1;
        end
        if (stomp_n) begin
          s_nxt.st = SQUASH;
          s_nxt.sq = '0;
        end
      end
      SQUASH: begin
        if (s.sq == SW'(SQUASH_TICKS - 1)) s_nxt.st = DEAD;
        else                               s_nxt.sq = s.sq + 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    alive_now = '0;
    for (int i = 0; i < 4; i++) alive_now = alive_now + 3'(slots[i].st == ALIVE);
  end

  always_ff @(posedge sys_clk) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  // A tick arriving mid-scan is dropped: only IDLE looks at it
  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE:    state_nxt = tick_wrap ? S0 : IDLE;
      S0:      state_nxt = S1;
      S1:      state_nxt = S2;
      S2:      state_nxt = S3;
      S3:      state_nxt = REPORT;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    stomp = (state == REPORT) && stomp_hit;
    death = (state == REPORT) && side_hit && !stomp_hit;
  end

  always_ff @(posedge sys_clk) begin
    if (RST) begin
      for (int i = 0; i < 4; i++) begin
        slots[i].st  <= ALIVE;
        slots[i].x   <= SPAWN_X[i];
        slots[i].dir <= 1'b0;
        slots[i].leg <= '0;
        slots[i].sq  <= '0;
      end
      tick_cnt   <= '0;
      stomp_hit  <= 1'b0;
      side_hit   <= 1'b0;
      stomp_slot <= 2'd0;
      alive_cnt  <= 3'd4;
    end else begin
      tick_cnt <= tick_wrap ? '0 : tick_cnt + 1'b1;
      if (in_slot) begin
        slots[cur] <= s_nxt;
        // ascending scan order: the first stomp of the scan is the lowest slot
        if (hit_stomp && !stomp_hit) stomp_slot <= cur;
        if (hit_stomp) stomp_hit <= 1'b1;
        if (hit_side)  side_hit  <= 1'b1;
      end
      if (state == REPORT) begin
        alive_cnt <= alive_now;
        stomp_hit <= 1'b0;
        side_hit  <= 1'b0;
      end
    end
  end

  assign rd_x      = slots[rd_slot].x - bg_pos;
  assign rd_y      = 10'(SPAWN_Y);
  assign rd_en     = slots[rd_slot].st != DEAD;
  assign rd_squash = slots[rd_slot].st == SQUASH;
endmodule

// File: tb/tb_goomba_ctrl.sv
// Scoreboard bench for goomba_ctrl: expected stomp/death events are queued by
// the stimulus and consumed by a monitor; slot readouts are checked directly.
module tb_goomba_ctrl;
  localparam int TD = 10;

  logic       sys_clk = 1'b0;
  logic       RST = 1'b1;
  logic [9:0] char_X = '0, char_Y = '0, bg_pos = '0;
  logic       char_falling = 1'b0;
  logic [1:0] rd_slot = '0;
  logic [9:0] rd_x, rd_y;
  logic       rd_en, rd_squash, death, stomp;
  logic [1:0] stomp_slot;
  logic [2:0] alive_cnt;

  typedef struct { bit stomp; int slot; bit death; } ev_t;
  ev_t exp_q[$];
  int  checks = 0, errors = 0;

  goomba_ctrl #(.TICK_DIV(TD)) dut (
    .sys_clk(sys_clk), .RST(RST), .char_X(char_X), .char_Y(char_Y),
    .char_falling(char_falling), .bg_pos(bg_pos), .rd_slot(rd_slot),
    .rd_x(rd_x), .rd_y(rd_y), .rd_en(rd_en), .rd_squash(rd_squash),
    .death(death), .stomp(stomp), .stomp_slot(stomp_slot), .alive_cnt(alive_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Monitor: every cycle with a pulse must match the next queued event
  always @(negedge sys_clk) begin
    if (stomp === 1'b1 || death === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event got stomp=%0b slot=%0d death=%0b expected none",
                 stomp, stomp_slot, death);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        chk("ev_stomp", int'(stomp), int'(e.stomp));
        if (e.stomp) chk("ev_stomp_slot", int'(stomp_slot), e.slot);
        chk("ev_death", int'(death), int'(e.death));
      end
    end
  end

  task automatic push_ev(input bit st, input int sl, input bit de);
    ev_t e;
    e.stomp = st; e.slot = sl; e.death = de;
    exp_q.push_back(e);
  endtask

  task automatic drain_chk();
    chk("queued_events_missing", exp_q.size(), 0);
    exp_q.delete();
  endtask

  // Leaves the bench 6 cycles past a tick wrap: tick_cnt=6, scan idle
  task automatic do_reset();
    @(posedge sys_clk); #1 RST = 1'b1;
    @(posedge sys_clk); @(posedge sys_clk); #1 RST = 1'b0;
    repeat (6) @(posedge sys_clk);
    #1;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      repeat (TD) @(posedge sys_clk);
      #1;
      drain_chk();
    end
  endtask

  task automatic rd_chk(input string nm, input int sl, input int x, input bit en, input bit sq);
    rd_slot = 2'(sl); #1;
    chk({nm, "_x"}, int'(rd_x), x);
    chk({nm, "_en"}, int'(rd_en), int'(en));
    chk({nm, "_sq"}, int'(rd_squash), int'(sq));
  endtask

  task automatic set_char(input int x, input int y, input bit f);
    char_X = 10'(x); char_Y = 10'(y); char_falling = f;
  endtask

  initial begin
    // reset state and one patrol step
    do_reset();
    rd_chk("rst_s0", 0, 112, 1, 0);
    rd_chk("rst_s1", 1, 300, 1, 0);
    rd_chk("rst_s2", 2, 520, 1, 0);
    rd_chk("rst_s3", 3, 700, 1, 0);
    chk("rst_y", int'(rd_y), 366);
    chk("rst_alive", int'(alive_cnt), 4);
    tick(1);
    rd_chk("t1_s0", 0, 111, 1, 0);
    rd_chk("t1_s1", 1, 299, 1, 0);
    rd_chk("t1_s3", 3, 699, 1, 0);
    chk("t1_alive", int'(alive_cnt), 4);
    bg_pos = 10'd200;
    rd_chk("t1_scroll_wrap", 0, 935, 1, 0);
    bg_pos = '0;

    // patrol leg turn-around
    tick(99);
    rd_chk("t100_s0", 0, 12, 1, 0);
    rd_chk("t100_s3", 3, 600, 1, 0);
    tick(1);
    rd_chk("t101_s0", 0, 13, 1, 0);
    rd_chk("t101_s1", 1, 201, 1, 0);

    // stomp slot0, squash lifetime
    do_reset();
    set_char(108, 350, 1);
    push_ev(1, 0, 0);
    tick(1);
    set_char(0, 0, 0);
    rd_chk("sq_t1", 0, 111, 1, 1);
    chk("sq_alive", int'(alive_cnt), 3);
    for (int k = 2; k <= 5; k++) begin
      tick(1);
      rd_chk($sformatf("sq_t%0d", k), 0, 111, 1, 1);
    end
    tick(1);
    rd_chk("sq_dead", 0, 111, 0, 0);
    chk("sq_dead_alive", int'(alive_cnt), 3);

    // side contact window edges
    do_reset();
    set_char(122, 360, 0);
    push_ev(0, 0, 1);
    tick(1);
    tick(1);                 // gx=110, char 12 px right: no hit
    set_char(98, 360, 0);    // gx=109, char 11 px left: hit
    push_ev(0, 0, 1);
    tick(1);
    set_char(0, 0, 0);
    chk("side_alive", int'(alive_cnt), 4);

    // two stomps plus side contact in one scan, inputs switched per slot
    do_reset();
    push_ev(1, 1, 0);
    repeat (4) @(posedge sys_clk);
    #1 set_char(0, 0, 0);
    @(posedge sys_clk); #1 set_char(299, 350, 1);
    @(posedge sys_clk); #1 set_char(519, 350, 1);
    @(posedge sys_clk); #1 set_char(699, 360, 0);
    @(posedge sys_clk); #1 set_char(0, 0, 0);
    repeat (TD - 8) @(posedge sys_clk);
    #1;
    drain_chk();
    chk("multi_alive", int'(alive_cnt), 2);
    rd_chk("multi_s1", 1, 299, 1, 1);
    rd_chk("multi_s2", 2, 519, 1, 1);
    rd_chk("multi_s3", 3, 699, 1, 0);

    // reset during S2 discards the scan
    do_reset();
    set_char(108, 350, 1);
    repeat (6) @(posedge sys_clk);
    #1 RST = 1'b1;
    @(posedge sys_clk);
    #1 RST = 1'b0;
    set_char(0, 0, 0);
    repeat (6) @(posedge sys_clk);
    #1;
    rd_chk("mid_rst_s0", 0, 112, 1, 0);
    rd_chk("mid_rst_s1", 1, 300, 1, 0);
    rd_chk("mid_rst_s2", 2, 520, 1, 0);
    chk("mid_rst_alive", int'(alive_cnt), 4);
    tick(1);
    rd_chk("mid_rst_t1_s0", 0, 111, 1, 0);
    rd_chk("mid_rst_t1_s2", 2, 519, 1, 0);

    repeat (3) @(posedge sys_clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
